// File: rtl/tmds_encoder_pipe_if.sv
// rtl/tmds_encoder_pipe_if.sv - pixel-side bundle for the multi-lane TMDS encoder
interface tmds_encoder_pipe_if #(
   parameter int NCH   = 3,
   parameter int CNT_W = 5
);
   logic                   ce;
   logic [1:0]             mode;
   logic [8*NCH-1:0]       vd;
   logic [2*NCH-1:0]       cd;
   logic [4*NCH-1:0]       terc4;
   logic [10*NCH-1:0]      tmds;
   logic [CNT_W*NCH-1:0]   disp;

   modport master (output ce, mode, vd, cd, terc4, input tmds, disp);
   modport slave  (input ce, mode, vd, cd, terc4, output tmds, disp);
endinterface

// File: rtl/tmds_encoder_pipe.sv
// rtl/tmds_encoder_pipe.sv - 2-stage TMDS/TERC4/guard-band encoder, NCH independent lanes
module tmds_encoder_pipe #(
   parameter int NCH   = 3,
   parameter int CNT_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   tmds_encoder_pipe_if.slave    bus
);
   localparam logic [1:0] MODE_CTRL  = 2'b00;
   localparam logic [1:0] MODE_VIDEO = 2'b01;
   localparam logic [1:0] MODE_TERC4 = 2'b10;
   localparam logic [1:0] MODE_GUARD = 2'b11;

   localparam logic [9:0] CTRL00  = 10'b1101010100;
   localparam logic [9:0] CTRL01  = 10'b0010101011;
   localparam logic [9:0] CTRL10  = 10'b0101010100;
   localparam logic [9:0] CTRL11  = 10'b1010101011;
   localparam logic [9:0] GB_ODD  = 10'b0100110011;
   localparam logic [9:0] GB_EVEN = 10'b1011001100;

   localparam logic signed [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);
   localparam logic signed [CNT_W-1:0] ZERO  = '0;

   function automatic logic [9:0] terc4_code(input logic [3:0] n);
      case (n)
         4'h0: terc4_code = 10'b1010011100;
         4'h1: terc4_code = 10'b1001100011;
         4'h2: terc4_code = 10'b1011100100;
         4'h3: terc4_code = 10'b1011100010;
         4'h4: terc4_code = 10'b0101110001;
         4'h5: terc4_code = 10'b0100011110;
         4'h6: terc4_code = 10'b0110001110;
         4'h7: terc4_code = 10'b0100111100;
         4'h8: terc4_code = 10'b1011001100;
         4'h9: terc4_code = 10'b0100111001;
         4'hA: terc4_code = 10'b0110011100;
         4'hB: terc4_code = 10'b1011000110;
         4'hC: terc4_code = 10'b1010001110;
         4'hD: terc4_code = 10'b1001110001;
         4'hE: terc4_code = 10'b0101100011;
         default: terc4_code = 10'b1011000011;
      endcase
   endfunction

   // Mode is shared by all lanes, so one stage-1 copy drives every lane's stage 2.
   logic [1:0] s1_mode;

   always_ff @(posedge clk) begin
      if (!rst_n)
         s1_mode <= MODE_CTRL;
      else if (bus.ce)
         s1_mode <= bus.mode;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      logic [7:0]              d;
      logic [3:0]              d_n1;
      logic                    use_xnor;
      logic [8:0]              qm_d;
      logic [9:0]              sym_d;
      logic [8:0]              s1_qm;
      logic [3:0]              s1_n1;
      logic [9:0]              s1_sym;
      logic [9:0]              s2_tmds;
      logic [9:0]              vid_d;
      logic signed [CNT_W-1:0] cnt;
      logic signed [CNT_W-1:0] cnt_d;
      logic signed [CNT_W-1:0] diff;

      assign d        = bus.vd[8*i +: 8];
      assign d_n1     = 4'($countones(d));
      assign use_xnor = (d_n1 > 4'd4) || (d_n1 == 4'd4 && !d[0]);

      always_comb begin
         qm_d    = '0;
         qm_d[0] = d[0];
         for (int k = 1; k < 8; k++)
            qm_d[k] = use_xnor ? ~(qm_d[k-1] ^ d[k]) : (qm_d[k-1] ^ d[k]);
         qm_d[8] = ~use_xnor;
      end

      // Non-video symbols are fully decided in stage 1; stage 2 just forwards them.
      always_comb begin
         sym_d = CTRL00;
         case (bus.mode)
            MODE_CTRL: begin
               case (bus.cd[2*i +: 2])
                  2'b00:   sym_d = CTRL00;
                  2'b01:   sym_d = CTRL01;
                  2'b10:   sym_d = CTRL10;
                  default: sym_d = CTRL11;
               endcase
            end
            MODE_TERC4: sym_d = terc4_code(bus.terc4[4*i +: 4]);
            MODE_GUARD: sym_d = (i % 3 == 1) ? GB_ODD : GB_EVEN;
            default:    sym_d = CTRL00;
         endcase
      end

      // diff = N1 - N0 = 2*N1 - 8 of the stage-1 q_m byte
      always_comb begin
         diff = CNT_W'({s1_n1, 1'b0}) - EIGHT;
         if (cnt == ZERO || s1_n1 == 4'd4) begin
            vid_d = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            cnt_d = s1_qm[8] ? cnt + diff : cnt - diff;
         end else if ((!cnt[CNT_W-1] && s1_n1 > 4'd4) || (cnt[CNT_W-1] && s1_n1 < 4'd4)) begin
            vid_d = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            cnt_d = cnt + (s1_qm[8] ? TWO : ZERO) - diff;
         end else begin
            vid_d = {1'b0, s1_qm[8], s1_qm[7:0]};
            cnt_d = cnt + diff - (s1_qm[8] ? ZERO : TWO);
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            s1_qm   <= '0;
            s1_n1   <= '0;
            s1_sym  <= CTRL00;
            s2_tmds <= CTRL00;
            cnt     <= '0;
         end else if (bus.ce) begin
            s1_qm  <= qm_d;
            s1_n1  <= 4'($countones(qm_d[7:0]));
            s1_sym <= sym_d;
            if (s1_mode == MODE_VIDEO) begin
               s2_tmds <= vid_d;
               cnt     <= cnt_d;
            end else begin
               s2_tmds <= s1_sym;
               cnt     <= '0;
            end
         end
      end

      assign bus.tmds[10*i +: 10]       = s2_tmds;
      assign bus.disp[CNT_W*i +: CNT_W] = cnt;
   end
endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// tb/tb_tmds_encoder_pipe.sv - randomized self-checking bench for tmds_encoder_pipe
module tb_tmds_encoder_pipe;
   localparam int NCH   = 3;
   localparam int CNT_W = 5;
   localparam int VW    = 8*NCH;
   localparam int CW    = 2*NCH;
   localparam int TW    = 4*NCH;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   tmds_encoder_pipe_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();
   tmds_encoder_pipe #(.NCH(NCH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   logic [9:0] ctrl_tab [4]  = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
   logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   int          m_cnt  [NCH];
   logic [9:0]  m_tmds [NCH];
   logic [1:0]  p_mode;
   logic [VW-1:0] p_vd;
   logic [CW-1:0] p_cd;
   logic [TW-1:0] p_t4;

   function automatic void enc_video(input int l, input logic [7:0] d);
      int n1d, n1, n0;
      logic [7:0] q;
      logic q8, use_xnor;
      n1d = $countones(d);
      use_xnor = (n1d > 4) || (n1d == 4 && !d[0]);
      q = '0;
      q[0] = d[0];
      for (int k = 1; k < 8; k++) q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
      q8 = ~use_xnor;
      n1 = $countones(q);
      n0 = 8 - n1;
      if (m_cnt[l] == 0 || n1 == n0) begin
         m_tmds[l] = {~q8, q8, q8 ? q : ~q};
         m_cnt[l] += q8 ? (n1 - n0) : (n0 - n1);
      end else if ((m_cnt[l] > 0 && n1 > n0) || (m_cnt[l] < 0 && n0 > n1)) begin
         m_tmds[l] = {1'b1, q8, ~q};
         m_cnt[l] += 2*int'(q8) + n0 - n1;
      end else begin
         m_tmds[l] = {1'b0, q8, q};
         m_cnt[l] += n1 - n0 - 2*int'(!q8);
      end
   endfunction

   // Reference: the symbol accepted on one enabled edge emerges on the next.
   function automatic void model_edge();
      if (!rst_n) begin
         for (int l = 0; l < NCH; l++) begin m_tmds[l] = ctrl_tab[0]; m_cnt[l] = 0; end
         p_mode = 2'b00; p_vd = '0; p_cd = '0; p_t4 = '0;
      end else if (bus.ce) begin
         for (int l = 0; l < NCH; l++) begin
            if (p_mode == 2'b01) enc_video(l, p_vd[8*l +: 8]);
            else begin
               m_cnt[l] = 0;
               if (p_mode == 2'b00)      m_tmds[l] = ctrl_tab[p_cd[2*l +: 2]];
               else if (p_mode == 2'b10) m_tmds[l] = terc_tab[p_t4[4*l +: 4]];
               else                      m_tmds[l] = (l % 3 == 1) ? 10'b0100110011 : 10'b1011001100;
            end
         end
         p_mode = bus.mode; p_vd = bus.vd; p_cd = bus.cd; p_t4 = bus.terc4;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.ce = 1'b0; bus.mode = 2'b01; bus.vd = VW'($urandom); bus.cd = '1; bus.terc4 = '1;
      do_reset(2);
      for (int l = 0; l < NCH; l++) begin
         checks++;
         if (bus.tmds[10*l +: 10] !== 10'b1101010100) begin
            errors++; $display("FAIL reset_tmds lane %0d got %b exp 1101010100", l, bus.tmds[10*l +: 10]);
         end
         checks++;
         if (bus.disp[CNT_W*l +: CNT_W] !== '0) begin
            errors++; $display("FAIL reset_disp lane %0d got %0d exp 0", l, bus.disp[CNT_W*l +: CNT_W]);
         end
      end
   endtask

   task automatic test_control();
      bus.ce = 1'b1; bus.mode = 2'b00; bus.cd = {2'b00, 2'b01, 2'b11};
      tick(); tick();
      checks++;
      if (bus.tmds[9:0] !== 10'b1010101011) begin
         errors++; $display("FAIL ctrl_lane0 got %b exp 1010101011", bus.tmds[9:0]);
      end
      checks++;
      if (bus.tmds[19:10] !== 10'b0010101011) begin
         errors++; $display("FAIL ctrl_lane1 got %b exp 0010101011", bus.tmds[19:10]);
      end
      for (int n = 0; n < 8; n++) begin
         bus.cd = CW'($urandom);
         tick();
         for (int l = 0; l < NCH; l++) begin
            checks++;
            if (bus.tmds[10*l +: 10] !== m_tmds[l]) begin
               errors++; $display("FAIL ctrl_rand lane %0d got %b exp %b", l, bus.tmds[10*l +: 10], m_tmds[l]);
            end
         end
      end
   endtask

   task automatic test_video_zero();
      do_reset(1);
      bus.ce = 1'b1; bus.mode = 2'b01; bus.vd = '0;
      tick(); tick();
      checks++;
      if (bus.tmds[9:0] !== 10'b0100000000 || $signed(bus.disp[CNT_W-1:0]) !== -5'sd8) begin
         errors++; $display("FAIL video_first got %b/%0d exp 0100000000/-8", bus.tmds[9:0], $signed(bus.disp[CNT_W-1:0]));
      end
      tick();
      checks++;
      if (bus.tmds[9:0] !== 10'b1111111111 || $signed(bus.disp[CNT_W-1:0]) !== 5'sd2) begin
         errors++; $display("FAIL video_second got %b/%0d exp 1111111111/2", bus.tmds[9:0], $signed(bus.disp[CNT_W-1:0]));
      end
   endtask

   task automatic test_terc4_guard();
      do_reset(1);
      bus.ce = 1'b1; bus.mode = 2'b10; bus.terc4 = '0;
      tick(); tick();
      for (int l = 0; l < NCH; l++) begin
         checks++;
         if (bus.tmds[10*l +: 10] !== 10'b1010011100 || bus.disp[CNT_W*l +: CNT_W] !== '0) begin
            errors++; $display("FAIL terc4_0 lane %0d got %b/%0d exp 1010011100/0", l, bus.tmds[10*l +: 10], bus.disp[CNT_W*l +: CNT_W]);
         end
      end
      bus.mode = 2'b11;
      tick(); tick();
      checks++;
      if (bus.tmds !== {10'b1011001100, 10'b0100110011, 10'b1011001100}) begin
         errors++; $display("FAIL guard got %b exp 101100110001001100111011001100", bus.tmds);
      end
   endtask

   task automatic test_stall();
      logic [10*NCH-1:0]    held_t;
      logic [CNT_W*NCH-1:0] held_d;
      bus.ce = 1'b1; bus.mode = 2'b01;
      for (int n = 0; n < 4; n++) begin bus.vd = VW'($urandom); tick(); end
      for (int l = 0; l < NCH; l++) held_t[10*l +: 10] = m_tmds[l];
      for (int l = 0; l < NCH; l++) held_d[CNT_W*l +: CNT_W] = CNT_W'(m_cnt[l]);
      bus.ce = 1'b0;
      for (int n = 0; n < 2; n++) begin
         bus.vd = VW'($urandom);
         tick();
         checks++;
         if (bus.tmds !== held_t || bus.disp !== held_d) begin
            errors++; $display("FAIL stall_hold got %h/%h exp %h/%h", bus.tmds, bus.disp, held_t, held_d);
         end
      end
      bus.ce = 1'b1;
      for (int n = 0; n < 3; n++) begin
         bus.vd = VW'($urandom);
         tick();
         for (int l = 0; l < NCH; l++) begin
            checks++;
            if (bus.tmds[10*l +: 10] !== m_tmds[l] || bus.disp[CNT_W*l +: CNT_W] !== CNT_W'(m_cnt[l])) begin
               errors++; $display("FAIL stall_resume lane %0d got %b/%0d exp %b/%0d", l, bus.tmds[10*l +: 10], bus.disp[CNT_W*l +: CNT_W], m_tmds[l], m_cnt[l]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1);
      bus.ce = 1'b1; bus.mode = 2'b01; bus.vd = '0;
      tick(); tick();
      checks++;
      if ($signed(bus.disp[CNT_W-1:0]) !== -5'sd8) begin
         errors++; $display("FAIL midrst_pre got %0d exp -8", $signed(bus.disp[CNT_W-1:0]));
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (bus.tmds[9:0] !== 10'b1101010100 || bus.disp[CNT_W-1:0] !== '0) begin
         errors++; $display("FAIL midrst_hold got %b/%0d exp 1101010100/0", bus.tmds[9:0], bus.disp[CNT_W-1:0]);
      end
      rst_n = 1'b1;
      tick(); tick();
      checks++;
      if (bus.tmds[9:0] !== 10'b0100000000) begin
         errors++; $display("FAIL midrst_first got %b exp 0100000000", bus.tmds[9:0]);
      end
   endtask

   task automatic test_random();
      do_reset(1);
      for (int n = 0; n < 400; n++) begin
         bus.ce    = ($urandom_range(0, 3) != 0);
         bus.mode  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
         bus.vd    = VW'($urandom);
         bus.cd    = CW'($urandom);
         bus.terc4 = TW'($urandom);
         tick();
         for (int l = 0; l < NCH; l++) begin
            checks++;
            if (bus.tmds[10*l +: 10] !== m_tmds[l] || bus.disp[CNT_W*l +: CNT_W] !== CNT_W'(m_cnt[l])) begin
               errors++; $display("FAIL random cyc %0d lane %0d got %b/%0d exp %b/%0d", n, l, bus.tmds[10*l +: 10], bus.disp[CNT_W*l +: CNT_W], m_tmds[l], m_cnt[l]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.ce = 1'b0; bus.mode = 2'b00; bus.vd = '0; bus.cd = '0; bus.terc4 = '0;
      test_reset();
      test_control();
      test_video_zero();
      test_terc4_guard();
      test_stall();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tmds_encoder_pipe.md
TMDS_ENCODER_PIPE -- requirements
Module: tmds_encoder_pipe

Interface
REQ-001 SHALL provide parameter NCH, default 3, number of independent TMDS lanes encoded in parallel (1..8).
REQ-002 SHALL provide parameter CNT_W, default 5, width of each lane's signed two's-complement running-disparity counter.
REQ-003 SHALL provide port clk  input  1  the single clock, rising-edge active; all state changes on it.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL provide port ce  input  1  pixel clock enable; the pipeline advances only when ce=1.
REQ-006 SHALL provide port mode  input  2  period type shared by all lanes: 00 control, 01 video, 10 TERC4 data island, 11 video guard band.
REQ-007 SHALL provide port vd  input  8*NCH  video bytes; lane i is vd[8i+7:8i].
REQ-008 SHALL provide port cd  input  2*NCH  control bits {c1,c0}; lane i is cd[2i+1:2i].
REQ-009 SHALL provide port terc4  input  4*NCH  data-island nibbles; lane i is terc4[4i+3:4i].
REQ-010 SHALL provide port tmds  output  10*NCH  encoded symbols; lane i is tmds[10i+9:10i], bit 0 transmitted first.
REQ-011 SHALL provide port disp  output  CNT_W*NCH  per-lane running disparity, stage-2 value, for debug.

Function
REQ-012 SHALL implement a 2-stage pipeline: tmds reflects the inputs sampled 2 ce-enabled clk edges earlier.
REQ-013 SHALL, when ce=0, hold all pipeline registers, tmds and disp unchanged.
REQ-014 Stage 1 SHALL register mode, q_m[8:0] and N1(q_m[7:0]) per lane, plus the pre-decoded control/TERC4/guard symbol.
REQ-015 q_m SHALL use XNOR when N1(vd)>4, or N1(vd)=4 with vd[0]=0; otherwise XOR. Then q_m[0]=vd[0], q_m[k]=q_m[k-1] op vd[k], q_m[8]=0 for XNOR and 1 for XOR.
REQ-016 Stage 2 in video mode, case A (cnt=0 or N1=N0=4): out={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}. cnt += (q_m[8] ? N1-N0 : N0-N1).
REQ-017 Case B (cnt>0 and N1>N0, or cnt<0 and N0>N1): out={1,q_m[8],~q_m[7:0]}. cnt += 2*q_m[8] + N0-N1.
REQ-018 Case C (otherwise): out={0,q_m[8],q_m[7:0]}. cnt += N1-N0 - 2*(~q_m[8]).
REQ-019 Disparity arithmetic SHALL be signed CNT_W-bit. With default CNT_W the DVI-bounded range never wraps.
REQ-020 Control mode SHALL output per cd: 00->1101010100, 01->0010101011, 10->0101010100, 11->1010101011.
REQ-021 TERC4 mode SHALL output the HDMI 1.4 TERC4 code for the nibble, e.g. 0000->1010011100, 1111->1011000011.
REQ-022 Guard-band mode SHALL output 0100110011 for lanes with i mod 3 = 1, and 1011001100 for all other lanes.
REQ-023 Each lane's cnt SHALL clear to 0 on every ce-enabled edge whose stage-2 mode is not video.
REQ-024 Mode changes SHALL take effect per symbol, with no bubble or extra latency.
REQ-025 Lanes SHALL be fully independent; the per-lane disparity state SHALL NOT be shared.

Reset
REQ-026 While rst_n=0 at a clk edge, regardless of ce: every lane's tmds SHALL be 1101010100, disp SHALL be 0, and stage-1 SHALL be loaded as control mode with cd=00.
REQ-027 After rst_n rises, the first input-derived symbol SHALL appear on the 2nd ce-enabled edge.
REQ-028 Reset asserted mid-video SHALL discard in-flight symbols and disparity history.

Verification
REQ-029 Reset: hold rst_n=0 for 2 edges -> all lanes tmds=1101010100, disp=0.
REQ-030 Control: mode=00, ce=1, lane0 cd=11, lane1 cd=01 -> 2 edges later lane0=1010101011, lane1=0010101011.
REQ-031 Video, cnt=0: vd=00 for two symbols -> 0100000000 with disp=-8, then 1111111111 with disp=+2.
REQ-032 TERC4 then guard band: terc4=0000 gives 1010011100, disp=0. Mode 11 then gives lane0=1011001100, lane1=0100110011, lane2=1011001100.
REQ-033 ce stall: toggle ce 1,0,0,1 during video -> tmds and disp frozen for 2 edges, and the sequence matches an unstalled run.
REQ-034 Reset mid-stream: disp=-8, pulse rst_n low, resend vd=00 in video -> first video symbol=0100000000.
